// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, reads the word-indexed instruction memory
// combinationally and queues {pc, instr} pairs in a 2-entry buffer for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEM_WORDS    = 256,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_pc_d    [2];
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];

  logic deq, in_range, zero_word, space, enq;
  logic [1:0] fill;

  // Fetch qualification and handshake decode
  always_comb begin
    deq       = out_valid && out_ready;
    in_range  = {2'b00, pc_q[31:2]} < MEM_WORDS;
    zero_word = HALT_ON_ZERO && (imem_rdata == 32'h0);
    space     = (count_q < 2'd2) || deq;
    enq       = (state_q == StRun) && in_range && !zero_word && space;
  end

  // Next-state: redirect flushes everything, otherwise dequeue/enqueue the buffer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    fill        = count_q;
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = StRun;
    end else begin
      if ((state_q == StRun) && (!in_range || zero_word)) begin
        state_d = StHalt;
      end
      if (deq) begin
        buf_pc_d[0]    = buf_pc_q[1];
        buf_instr_d[0] = buf_instr_q[1];
        fill           = count_q - 2'd1;
      end
      // enq implies fill <= 1, so bit 0 selects the free slot
      if (enq) begin
        buf_pc_d[fill[0]]    = pc_q;
        buf_instr_d[fill[0]] = imem_rdata;
        fill                 = fill + 2'd1;
        pc_d                 = pc_q + 32'd4;
      end
      count_d = fill;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      buf_pc_q    <= '{default: 32'h0};
      buf_instr_q <= '{default: 32'h0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // Outputs: head of buffer, forced to zero when empty
  always_comb begin
    imem_addr = {2'b00, pc_q[31:2]};
    out_valid = (count_q != 2'd0);
    out_instr = out_valid ? buf_instr_q[0] : 32'h0;
    out_pc    = out_valid ? buf_pc_q[0] : 32'h0;
    halted    = (state_q == StHalt);
  end

endmodule
